// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator with a built-in pixel-clock enable divider.
//   A divider produces a one-clk pix_tick every CLK_DIV system clocks; the
//   horizontal/vertical counters advance on pix_tick edges, and a registered
//   output stage produces sync, blanking flag and blanked colour that lag the
//   coordinates by exactly one pixel.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       run when high; low returns synchronously to the reset state
//   rgb_in       pixel colour for the current hcount/vcount (from drawing logic)
//   pix_tick     pixel-rate enable, one clk wide
//   hcount       current pixel column, 0..H_TOTAL-1
//   vcount       current line, 0..V_TOTAL-1
//   line_start   one clk pulse when hcount wraps to 0
//   frame_start  one clk pulse when hcount and vcount both wrap to 0
//   hsync        horizontal sync (active level HS_POL), registered
//   vsync        vertical sync (active level VS_POL), registered
//   video_on     visible-region flag, registered
//   rgb          colour to DAC, 0 outside the visible region
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10,
  parameter int RGB_W    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             pix_tick,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [RGB_W-1:0] rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             h_last;
  logic             v_last;
  logic             visible;
  logic             in_hsync;
  logic             in_vsync;

  always_comb begin
    div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
    h_last   = (hcount == H_LAST);
    v_last   = (vcount == V_LAST);
    visible  = (hcount < H_VIS) && (vcount < V_VIS);
    in_hsync = (hcount >= HS_BEG) && (hcount < HS_END);
    in_vsync = (vcount >= VS_BEG) && (vcount < VS_END);
  end

  // pix_tick is registered from the divider's next value so that it is high
  // exactly while div == CLK_DIV-1 (and constantly high once running when
  // CLK_DIV == 1), yet still comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      pix_tick    <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b0;
      rgb         <= '0;
    end else if (!enable) begin
      div         <= '0;
      pix_tick    <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b0;
      rgb         <= '0;
    end else begin
      div         <= div_next;
      pix_tick    <= (div_next == DIV_LAST);
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_tick) begin
        if (h_last) begin
          hcount     <= '0;
          line_start <= 1'b1;
          if (v_last) begin
            vcount      <= '0;
            frame_start <= 1'b1;
          end else begin
            vcount <= vcount + 1'b1;
          end
        end else begin
          hcount <= hcount + 1'b1;
        end
        // Output stage samples the pre-edge coordinates: one pixel of lag.
        video_on <= visible;
        hsync    <= in_hsync ? HS_POL : ~HS_POL;
        vsync    <= in_vsync ? VS_POL : ~VS_POL;
        rgb      <= visible ? rgb_in : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  localparam int D   = 2;
  localparam int HA  = 8;
  localparam int HF  = 2;
  localparam int HSW = 3;
  localparam int HB  = 3;
  localparam int VA  = 4;
  localparam int VF  = 1;
  localparam int VSW = 2;
  localparam int VB  = 2;
  localparam int HT  = HA + HF + HSW + HB;  // 16
  localparam int VT  = VA + VF + VSW + VB;  // 9
  localparam bit HP  = 1'b0;
  localparam bit VP  = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] rgb_in;
  logic        pix_tick;
  logic [4:0]  hcount;
  logic [4:0]  vcount;
  logic        line_start;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [11:0] rgb;

  vga_timing_gen #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .CNT_W(5), .RGB_W(12)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .rgb_in(rgb_in),
    .pix_tick(pix_tick), .hcount(hcount), .vcount(vcount),
    .line_start(line_start), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb(rgb)
  );

  // Drawing logic: a colour unique to each coordinate, never zero.
  assign rgb_in = {4'hA, hcount[3:0], vcount[3:0]};

  always #5 clk = ~clk;

  typedef struct {
    logic        pix;
    int          h;
    int          v;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        von;
    logic [11:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n = 0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Closed-form expectation after the n-th enabled clk edge (n=0: reset state).
  function automatic exp_t model(input int k);
    exp_t r;
    int p, q, qh, qv;
    r.pix = 1'b0; r.h = 0; r.v = 0; r.ls = 1'b0; r.fs = 1'b0;
    r.hs = !HP; r.vs = !VP; r.von = 1'b0; r.rgb = '0;
    if (k > 0) begin
      p     = k / D;
      r.pix = ((k % D) == D - 1);
      r.h   = p % HT;
      r.v   = (p / HT) % VT;
      r.ls  = ((k % D) == 0) && (p > 0) && ((p % HT) == 0);
      r.fs  = r.ls && (((p / HT) % VT) == 0);
      if (p > 0) begin
        q     = p - 1;
        qh    = q % HT;
        qv    = (q / HT) % VT;
        r.von = (qh < HA) && (qv < VA);
        r.hs  = (qh >= HA + HF && qh < HA + HF + HSW) ? HP : !HP;
        r.vs  = (qv >= VA + VF && qv < VA + VF + VSW) ? VP : !VP;
        r.rgb = r.von ? {4'hA, qh[3:0], qv[3:0]} : 12'h000;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset || !enable) n = 0;
    else n++;
    exp_q.push_back(model(n));
  end

  always @(posedge clk) begin
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("pix_tick", pix_tick, e.pix);
      chk("hcount", hcount, e.h);
      chk("vcount", vcount, e.v);
      chk("line_start", line_start, e.ls);
      chk("frame_start", frame_start, e.fs);
      chk("hsync", hsync, e.hs);
      chk("vsync", vsync, e.vs);
      chk("video_on", video_on, e.von);
      chk("rgb", rgb, e.rgb);
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_pix"}, pix_tick, 1'b0);
    chk({tag, "_h"}, hcount, 0);
    chk({tag, "_v"}, vcount, 0);
    chk({tag, "_ls"}, line_start, 1'b0);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_hs"}, hsync, !HP);
    chk({tag, "_vs"}, vsync, !VP);
    chk({tag, "_von"}, video_on, 1'b0);
    chk({tag, "_rgb"}, rgb, 12'h000);
  endtask

  initial begin
    int k, kls, t0, cnt;
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk_reset("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;

    // Frame period between frame_start pulses.
    k = 0;
    while (!frame_start && k < 2000) begin @(negedge clk); k++; end
    chk("fs_seen", frame_start, 1'b1);
    t0 = cyc;
    @(negedge clk);
    k = 0;
    while (!frame_start && k < 2000) begin @(negedge clk); k++; end
    chk("fs_period", cyc - t0, D * HT * VT);

    // Sync widths in clk cycles.
    cnt = 0;
    repeat (D * HT) begin @(negedge clk); if (hsync == HP) cnt++; end
    chk("hs_width", cnt, HSW * D);
    cnt = 0;
    repeat (D * HT * VT) begin @(negedge clk); if (vsync == VP) cnt++; end
    chk("vs_width", cnt, VSW * HT * D);

    // Asynchronous reset mid-frame, between clock edges.
    k = 0;
    while (!(hcount == 5 && vcount == 2) && k < 700) begin @(negedge clk); k++; end
    chk("reach_5_2", (k < 700), 1'b1);
    #2 reset = 1'b1;
    #1 chk_reset("async");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (D) @(negedge clk);
    chk("h_after_rst", hcount, 1);

    // Enable dropped mid-line for 10 clks.
    k = 0;
    while (hcount != 4 && k < 100) begin @(negedge clk); k++; end
    chk("reach_h4", (k < 100), 1'b1);
    enable = 1'b0;
    @(negedge clk);
    chk("h_after_drop", hcount, 0);
    chk("v_after_drop", vcount, 0);
    repeat (9) @(negedge clk);
    enable = 1'b1;
    k = 0;
    kls = -1;
    while (!frame_start && k < 1000) begin
      @(negedge clk);
      k++;
      if (line_start && kls < 0) kls = k;
    end
    chk("ls_first", kls, D * HT);
    chk("fs_first", k, D * HT * VT);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
